// File: rtl/deck_shuffler.sv
// Deck shuffler: fills a DECK_SIZE deck, Fisher-Yates shuffles it with a Galois LFSR
// using rejection sampling, then deals one card per valid/ready handshake.
module deck_shuffler #(
  parameter int                DECK_SIZE = 52,
  parameter int                CARD_W    = 6,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED_RST  = 16'h0001
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              card_valid,
  input  logic              card_ready,
  output logic [CARD_W-1:0] card_idx,
  output logic [3:0]        card_rank,
  output logic [4:0]        card_value,
  output logic [CARD_W:0]   cards_left,
  output logic              deck_empty
);

  // state   | meaning
  // IDLE    | waiting for start after reset
  // INIT    | writing deck[i] = i, one entry per cycle
  // SHUFFLE | Fisher-Yates from the top, redrawing rejected candidates
  // DEAL    | presenting deck[ptr] until cards run out or start reshuffles
  typedef enum logic [1:0] {S_IDLE, S_INIT, S_SHUFFLE, S_DEAL} state_t;

  localparam logic [CARD_W-1:0] LAST_IDX = CARD_W'(DECK_SIZE - 1);
  localparam logic [CARD_W:0]   FULL_CNT = (CARD_W + 1)'(DECK_SIZE);

  state_t              state_q, state_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [CARD_W-1:0]   i_q, i_d;
  logic [CARD_W-1:0]   ptr_q, ptr_d;
  logic [CARD_W:0]     left_q, left_d;
  logic                done_q, done_d;
  logic [CARD_W-1:0]   deck_q [DECK_SIZE];
  logic [CARD_W-1:0]   deck_d [DECK_SIZE];

  logic [CARD_W-1:0]   cand;
  logic [LFSR_W-1:0]   lfsr_step;
  logic                seed_ok;
  logic [CARD_W-1:0]   rank_rem;

  assign cand      = lfsr_q[CARD_W-1:0];
  assign lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
  assign seed_ok   = seed_load && (state_q == S_IDLE || state_q == S_DEAL);

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    i_d     = i_q;
    ptr_d   = ptr_q;
    left_d  = left_q;
    done_d  = 1'b0;
    deck_d  = deck_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_INIT;
          i_d     = '0;
        end
      end
      S_INIT: begin
        deck_d[i_q] = i_q;
        if (i_q == LAST_IDX) begin
          state_d = S_SHUFFLE;
          i_d     = LAST_IDX;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      S_SHUFFLE: begin
        lfsr_d = lfsr_step;
        if (cand <= i_q) begin
          deck_d[i_q]  = deck_q[cand];
          deck_d[cand] = deck_q[i_q];
          if (i_q == CARD_W'(1)) begin
            state_d = S_DEAL;
            done_d  = 1'b1;
            ptr_d   = '0;
            left_d  = FULL_CNT;
          end else begin
            i_d = i_q - 1'b1;
          end
        end
      end
      S_DEAL: begin
        // A reshuffle request discards the rest of the deck and beats a same-cycle accept.
        if (start) begin
          state_d = S_INIT;
          i_d     = '0;
          left_d  = '0;
        end else if (left_q != '0 && card_ready) begin
          ptr_d  = ptr_q + 1'b1;
          left_d = left_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (seed_ok) begin
      lfsr_d = (seed_in == '0) ? LFSR_W'(1) : seed_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED_RST;
      i_q     <= '0;
      ptr_q   <= '0;
      left_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      i_q     <= i_d;
      ptr_q   <= ptr_d;
      left_q  <= left_d;
      done_q  <= done_d;
    end
  end

  // Deck contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    deck_q <= deck_d;
  end

  assign busy       = (state_q == S_INIT) || (state_q == S_SHUFFLE);
  assign done       = done_q;
  assign card_valid = (state_q == S_DEAL) && (left_q != '0);
  assign deck_empty = (state_q == S_DEAL) && (left_q == '0);
  assign cards_left = left_q;
  assign card_idx   = card_valid ? deck_q[ptr_q] : '0;
  assign rank_rem   = card_idx % CARD_W'(13);
  assign card_rank  = card_valid ? (4'(rank_rem) + 4'd1) : 4'd0;
  assign card_value = (card_rank > 4'd10) ? 5'd10 : {1'b0, card_rank};

endmodule

// File: tb/tb_deck_shuffler.sv
// Bench for deck_shuffler: a reference shuffle model fills a queue of expected cards
// on every start; the deal loop pops and compares each presented card.
module tb_deck_shuffler;
  localparam int N = 52;

  logic        clk = 1'b0;
  logic        reset, seed_load, start, card_ready;
  logic [15:0] seed_in;
  logic        busy, done, card_valid, deck_empty;
  logic [5:0]  card_idx;
  logic [3:0]  card_rank;
  logic [4:0]  card_value;
  logic [6:0]  cards_left;

  deck_shuffler dut (
    .clk(clk), .reset(reset), .seed_load(seed_load), .seed_in(seed_in),
    .start(start), .busy(busy), .done(done), .card_valid(card_valid),
    .card_ready(card_ready), .card_idx(card_idx), .card_rank(card_rank),
    .card_value(card_value), .cards_left(cards_left), .deck_empty(deck_empty)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] m_lfsr;
  int          m_cycles;
  int          exp_q[$];
  int          last_order[N];
  int          order_a[N];

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic int rank_of(input int idx);
    return (idx % 13) + 1;
  endfunction

  function automatic int value_of(input int idx);
    return (rank_of(idx) > 10) ? 10 : rank_of(idx);
  endfunction

  task automatic model_shuffle();
    int d[N];
    int cand, tmp;
    bit swapped;
    for (int k = 0; k < N; k++) d[k] = k;
    m_cycles = 0;
    for (int i = N - 1; i >= 1; i--) begin
      swapped = 1'b0;
      while (!swapped) begin
        cand     = int'(m_lfsr[5:0]);
        m_lfsr   = lfsr_next(m_lfsr);
        m_cycles++;
        if (cand <= i) begin
          tmp = d[i]; d[i] = d[cand]; d[cand] = tmp;
          swapped = 1'b1;
        end
      end
    end
    exp_q.delete();
    for (int k = 0; k < N; k++) exp_q.push_back(d[k]);
  endtask

  // Called at a negedge; returns one negedge later with start released.
  task automatic kick(input bit use_seed, input logic [15:0] s, input logic rdy);
    if (use_seed) begin
      seed_load = 1'b1;
      seed_in   = s;
      m_lfsr    = (s == 16'h0) ? 16'h0001 : s;
    end
    start      = 1'b1;
    card_ready = rdy;
    model_shuffle();
    @(negedge clk);
    start      = 1'b0;
    seed_load  = 1'b0;
    card_ready = 1'b0;
  endtask

  task automatic wait_done(input bit poke_start);
    int cnt;
    cnt = 0;
    while (busy && cnt < 5000) begin
      cnt++;
      start = (poke_start && cnt == 60);
      @(negedge clk);
    end
    start = 1'b0;
    chk("busy_cycles", cnt, N + m_cycles);
    chk("done_pulse", done, 1);
    chk("valid_at_done", card_valid, 1);
    chk("left_at_done", cards_left, N);
    @(negedge clk);
    chk("done_once", done, 0);
  endtask

  task automatic check_card(input int k);
    int e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    chk("valid", card_valid, 1);
    chk("left", cards_left, N - k);
    chk("card_idx", card_idx, e);
    chk("card_rank", card_rank, rank_of(e));
    chk("card_value", card_value, value_of(e));
  endtask

  task automatic deal_all();
    int seen[N];
    int uniq;
    for (int k = 0; k < N; k++) seen[k] = 0;
    card_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      check_card(k);
      last_order[k] = int'(card_idx);
      if (int'(card_idx) < N) seen[card_idx]++;
      @(negedge clk);
    end
    chk("empty_valid", card_valid, 0);
    chk("deck_empty", deck_empty, 1);
    chk("empty_left", cards_left, 0);
    @(negedge clk);
    chk("empty_ready_ignored", cards_left, 0);
    card_ready = 1'b0;
    uniq = 0;
    for (int k = 0; k < N; k++) if (seen[k] == 1) uniq++;
    chk("permutation", uniq, N);
  endtask

  initial begin
    int diffs;
    reset = 1'b1; seed_load = 1'b0; start = 1'b0; card_ready = 1'b0; seed_in = '0;
    m_lfsr = 16'h0001;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", card_valid, 0);
    chk("rst_left", cards_left, 0);
    chk("rst_empty", deck_empty, 0);
    chk("rst_idx", card_idx, 0);
    chk("rst_rank", card_rank, 0);
    chk("rst_value", card_value, 0);
    reset = 1'b0;
    @(negedge clk);

    // Reset seed, no explicit load
    kick(1'b0, 16'h0, 1'b0);
    chk("busy_after_start", busy, 1);
    wait_done(1'b0);
    deal_all();

    kick(1'b1, 16'h0014, 1'b0);
    wait_done(1'b0);
    deal_all();
    for (int k = 0; k < N; k++) order_a[k] = last_order[k];

    kick(1'b1, 16'h0014, 1'b0);
    wait_done(1'b0);
    deal_all();
    diffs = 0;
    for (int k = 0; k < N; k++) if (order_a[k] != last_order[k]) diffs++;
    chk("same_seed_same_order", diffs, 0);

    kick(1'b1, 16'h0003, 1'b0);
    wait_done(1'b0);
    deal_all();
    diffs = 0;
    for (int k = 0; k < N; k++) if (order_a[k] != last_order[k]) diffs++;
    chk("other_seed_differs", int'(diffs > 0), 1);

    // Zero seed maps to 1
    kick(1'b1, 16'h0000, 1'b0);
    wait_done(1'b0);
    deal_all();

    // Back-pressure: presented card holds
    kick(1'b1, 16'h0014, 1'b0);
    wait_done(1'b0);
    repeat (5) begin
      chk("hold_idx", card_idx, exp_q[0]);
      chk("hold_rank", card_rank, rank_of(exp_q[0]));
      chk("hold_value", card_value, value_of(exp_q[0]));
      chk("hold_left", cards_left, N);
      chk("hold_valid", card_valid, 1);
      @(negedge clk);
    end
    deal_all();

    // Start during SHUFFLE must not disturb it
    kick(1'b1, 16'h0055, 1'b0);
    wait_done(1'b1);
    deal_all();

    // Start in DEAL together with card_ready reshuffles without consuming
    kick(1'b1, 16'h1234, 1'b0);
    wait_done(1'b0);
    card_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check_card(k);
      @(negedge clk);
    end
    kick(1'b0, 16'h0, 1'b1);
    chk("reshuffle_busy", busy, 1);
    chk("reshuffle_valid", card_valid, 0);
    wait_done(1'b0);
    deal_all();

    // Reset mid-SHUFFLE
    kick(1'b1, 16'h0014, 1'b0);
    repeat (60) @(negedge clk);
    chk("mid_shuffle_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", card_valid, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_left", cards_left, 0);
    reset = 1'b0;
    m_lfsr = 16'h0001;
    exp_q.delete();
    @(negedge clk);
    kick(1'b0, 16'h0, 1'b0);
    wait_done(1'b0);
    deal_all();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
